// File: rtl/spi_rx.sv
// SPI Mode 1 (CPOL=0, CPHA=1) master receive path: samples MISO on falling SCLK,
// shifts MSB first, and hands completed words out through a valid/ready register.
module spi_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             rx_en_i,
  input  logic             SCLK_i,
  input  logic             MISO_i,
  input  logic             rx_ready_i,
  input  logic             overrun_clr_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic             sclk_prev;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    count;

  logic             fall;
  logic             sample;
  logic             complete;
  logic [WIDTH-1:0] word;

  // SCLK is already synchronous to clock_i, so a single history bit is enough.
  assign fall     = sclk_prev & ~SCLK_i;
  assign sample   = rx_en_i & fall;
  assign complete = sample & (count == LAST_BIT);
  assign word     = {shift[WIDTH-2:0], MISO_i};
  assign busy_o   = (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= SCLK_i;
    end
  end

  // A dropped frame enable discards any partial word every cycle it is low.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shift <= '0;
      count <= '0;
    end else if (!rx_en_i || complete) begin
      shift <= '0;
      count <= '0;
    end else if (sample) begin
      shift <= word;
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else if (complete) begin
      rx_data_o  <= word;
      rx_valid_o <= 1'b1;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

  // Setting takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overrun_o <= 1'b0;
    end else if (complete && rx_valid_o && !rx_ready_i) begin
      overrun_o <= 1'b1;
    end else if (overrun_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx (WIDTH=8): directed scenarios followed by random
// words, compared against a word-level model of the receive register.
module tb_spi_rx;

  localparam int WIDTH = 8;

  logic             clock_i = 1'b0;
  logic             reset_ni;
  logic             rx_en_i;
  logic             SCLK_i;
  logic             MISO_i;
  logic             rx_ready_i;
  logic             overrun_clr_i;
  logic [WIDTH-1:0] rx_data_o;
  logic             rx_valid_o;
  logic             overrun_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;

  // Word-level model of what the consumer should see.
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_overrun;

  spi_rx #(.WIDTH(WIDTH)) dut (
    .clock_i       (clock_i),
    .reset_ni      (reset_ni),
    .rx_en_i       (rx_en_i),
    .SCLK_i        (SCLK_i),
    .MISO_i        (MISO_i),
    .rx_ready_i    (rx_ready_i),
    .overrun_clr_i (overrun_clr_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".data"},    32'(rx_data_o),  32'(m_data));
    check({tag, ".valid"},   32'(rx_valid_o), 32'(m_valid));
    check({tag, ".overrun"}, 32'(overrun_o),  32'(m_overrun));
  endtask

  task automatic model_reset();
    m_data    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // A word arrives; rdy/clr are the consumer inputs in that same cycle.
  task automatic model_complete(input logic [WIDTH-1:0] w, input logic rdy, input logic clr);
    if (m_valid && !rdy) m_overrun = 1'b1;
    else if (clr)        m_overrun = 1'b0;
    m_data  = w;
    m_valid = 1'b1;
  endtask

  // Drive nbits SCLK periods (4 clocks high, 4 low), MSB of w first.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits,
                           input logic rdy_last, input logic clr_last);
    for (int i = 0; i < nbits; i++) begin
      SCLK_i = 1'b1;
      MISO_i = w[WIDTH-1-i];
      repeat (4) @(negedge clock_i);
      SCLK_i = 1'b0;
      if (i == WIDTH - 1) begin
        rx_ready_i    = rdy_last;
        overrun_clr_i = clr_last;
      end
      @(negedge clock_i);
      rx_ready_i    = 1'b0;
      overrun_clr_i = 1'b0;
      check($sformatf("busy_bit%0d", i), 32'(busy_o), 32'((i + 1) % WIDTH != 0));
      if (i == WIDTH - 1) begin
        model_complete(w, rdy_last, clr_last);
        check_regs($sformatf("word_%02h", w));
      end
      repeat (3) @(negedge clock_i);
    end
  endtask

  task automatic pulse_ready();
    rx_ready_i = 1'b1;
    @(negedge clock_i);
    rx_ready_i = 1'b0;
    m_valid = 1'b0;
    check_regs("accept");
  endtask

  task automatic pulse_clear();
    overrun_clr_i = 1'b1;
    @(negedge clock_i);
    overrun_clr_i = 1'b0;
    m_overrun = 1'b0;
    check_regs("clear");
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic             r;
    logic             c;

    reset_ni      = 1'b0;
    rx_en_i       = 1'b0;
    SCLK_i        = 1'b0;
    MISO_i        = 1'b0;
    rx_ready_i    = 1'b0;
    overrun_clr_i = 1'b0;
    model_reset();

    // Reset state
    #22;
    check_regs("reset");
    check("reset.busy", 32'(busy_o), 32'd0);
    @(negedge clock_i);
    reset_ni = 1'b1;
    @(negedge clock_i);

    // Basic word with busy tracking
    rx_en_i = 1'b1;
    @(negedge clock_i);
    send_bits(8'hA5, 8, 1'b0, 1'b0);

    // Handshake
    pulse_ready();

    // Overrun, then clear
    send_bits(8'h3C, 8, 1'b0, 1'b0);
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    pulse_clear();
    // Clear coinciding with an overrunning completion: set wins
    send_bits(8'h77, 8, 1'b0, 1'b1);
    pulse_clear();
    pulse_ready();

    // Accept in the completion cycle of the second word
    send_bits(8'h12, 8, 1'b0, 1'b0);
    send_bits(8'h34, 8, 1'b1, 1'b0);
    pulse_ready();

    // Abort after 5 bits of 0xFF; SCLK keeps running while disabled
    send_bits(8'hFF, 5, 1'b0, 1'b0);
    rx_en_i = 1'b0;
    @(negedge clock_i);
    check("abort.busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      SCLK_i = 1'b1;
      MISO_i = 1'b1;
      repeat (4) @(negedge clock_i);
      SCLK_i = 1'b0;
      repeat (4) @(negedge clock_i);
      check($sformatf("abort.busy%0d", i), 32'(busy_o), 32'd0);
    end
    check_regs("abort");
    rx_en_i = 1'b1;
    @(negedge clock_i);
    send_bits(8'h81, 8, 1'b0, 1'b0);

    // Asynchronous reset mid-word
    send_bits(8'h5A, 3, 1'b0, 1'b0);
    #2 reset_ni = 1'b0;
    #1;
    model_reset();
    check_regs("async_rst");
    check("async_rst.busy", 32'(busy_o), 32'd0);
    @(negedge clock_i);
    reset_ni = 1'b1;
    @(negedge clock_i);
    send_bits(8'h5A, 8, 1'b0, 1'b0);

    // Random words with random consumer behaviour, back to back
    for (int n = 0; n < 24; n++) begin
      w = WIDTH'($urandom);
      r = 1'($urandom % 2);
      c = 1'($urandom % 2);
      send_bits(w, 8, r, c);
      case ($urandom % 4)
        0: pulse_ready();
        1: pulse_clear();
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
# spi_rx

Master-side SPI receive path for SPI Mode 1 (CPOL=0, CPHA=1). It samples MISO on each falling SCLK edge, shifts bits in MSB first, and presents each completed word through a valid/ready holding register with a sticky overrun flag. It sits next to the master's transmit path. It shares the same master clock generator (SCLK_i) and frame enable as the transmit path, and it delivers received words to the DAQ control logic.

## Interface
- WIDTH, default 8: bits per word; legal range ≥ 2.
- clock_i  in  1  system clock; all state updates on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- rx_en_i  in  1  frame active (chip select asserted). Low aborts and discards any partial word.
- SCLK_i  in  1  SPI clock from the master clock generator, synchronous to clock_i, idles low. Each SCLK high and low phase lasts ≥ 2 clock_i cycles.
- MISO_i  in  1  serial data from the slave. It changes after rising SCLK and is stable around the falling edge.
- rx_ready_i  in  1  consumer accepts rx_data_o when high together with rx_valid_o.
- overrun_clr_i  in  1  single-cycle clear of overrun_o.
- rx_data_o  out  WIDTH  last completed word, MSB = first bit received.
- rx_valid_o  out  1  rx_data_o holds an unconsumed word.
- overrun_o  out  1  sticky: a completed word overwrote an unconsumed word.
- busy_o  out  1  partial word in progress (bit count ≠ 0).

## Operation
- Edge detect: sclk_prev register tracks SCLK_i; reset value 0. The falling-edge condition is fall = sclk_prev & ~SCLK_i, evaluated combinationally in the cycle SCLK_i is first seen low.
- Sample: on a clock edge with rx_en_i & fall:
  - shift <= {shift[WIDTH-2:0], MISO_i}
  - bit count increments.
- Bit count: width $clog2(WIDTH). It counts 0..WIDTH-1 and returns to 0 on word completion.
- Word complete: a sample taken while count == WIDTH-1. On that same clock edge:
  - rx_data_o <= {shift[WIDTH-2:0], MISO_i}
  - rx_valid_o <= 1
  - count <= 0
  - shift <= 0
- Handshake: a cycle with rx_valid_o & rx_ready_i and no completion clears rx_valid_o on the next edge. rx_data_o is held until the next completion.
- Completion while rx_valid_o = 1:
  - With rx_ready_i = 1 in the same cycle: new word loads, rx_valid_o stays 1, no overrun.
  - With rx_ready_i = 0: new word overwrites rx_data_o, rx_valid_o stays 1, overrun_o <= 1.
- overrun_o clears on overrun_clr_i. If a set and a clear occur in the same cycle, the set wins.
- rx_en_i low:
  - count <= 0 and shift <= 0 each cycle; fall is ignored.
  - rx_data_o, rx_valid_o and overrun_o are unaffected; the handshake still operates.
- A falling edge that coincides with rx_en_i rising is sampled. Frame enable must lead the first falling SCLK edge by ≥ 1 cycle.
- busy_o = (count ≠ 0), combinational from the counter.

## Timing
- Reset (reset_ni low, asynchronous): rx_data_o = 0, rx_valid_o = 0, overrun_o = 0, busy_o = 0, shift = 0, count = 0, sclk_prev = 0.
- Reset mid-word: the partial word is lost. The first falling edge after release starts bit 0.
- Sample latency: MISO_i is captured at the clock edge ending the first cycle in which SCLK_i reads low.
- Word latency: rx_valid_o is high in the cycle after the WIDTH-th falling edge is detected. There are no extra pipeline stages.
- rx_valid_o deasserts one cycle after the accepting cycle.
- Throughput: one word per WIDTH SCLK periods. Back-to-back frames need no gap cycles.
- The last SCLK falling edge of a frame must precede rx_en_i deassertion by ≥ 1 clock_i cycle.

## Test plan
- Basic word, WIDTH=8: reset, rx_en_i=1, slave drives 0xA5 MSB first over 8 SCLK periods (4 clocks high, 4 low), rx_ready_i=0.
  - rx_data_o=0xA5 and rx_valid_o=1 one cycle after the 8th fall.
  - busy_o=1 from the 1st to the 7th fall, 0 after the 8th.
- Handshake: after the 0xA5 word, pulse rx_ready_i for one cycle.
  - rx_valid_o=0 next cycle.
  - rx_data_o stays 0xA5.
  - overrun_o=0.
- Overrun: receive 0x3C then 0xC3 with rx_ready_i held 0.
  - rx_data_o=0xC3, rx_valid_o=1, overrun_o=1.
  - After overrun_clr_i pulse, overrun_o=0.
  - Repeat with clear and completion in the same cycle: overrun_o stays 1.
- Simultaneous accept and complete: assert rx_ready_i exactly in the completion cycle of the second word (0x12 then 0x34).
  - rx_data_o=0x34, rx_valid_o=1, overrun_o=0.
- Abort: deassert rx_en_i after 5 bits of 0xFF, then reassert and receive 0x81.
  - busy_o=0 during abort.
  - Next word reads 0x81, not mixed with partial bits.
- Async reset mid-word: pull reset_ni low between clock edges after 3 bits.
  - All outputs 0 immediately, before any clock edge.
  - After release, a full 0x5A is received correctly.
